pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central stall/flush controller for the dual-issue pipeline. It merges per-stage stall requests into the shared `stall[3:0]` vector consumed by every inter-stage register (`if_id`, `id_ex`, `ex_mem`, `mem_wb`). It arbitrates exception and branch-mispredict flushes and drives `flush`/`flush_cause`. It also owns the redirect handshake with fetch, holding the new PC until fetch accepts it, and keeps stall/flush performance counters.

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC00380, target PC for all exceptions except ERET
- ERET_CODE, 32'h0000000E, `excp_type` value that denotes ERET

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stallreq_if  in  1  fetch stall request (icache miss)
- stallreq_id  in  1  decode/issue stall request (issue hazard)
- stallreq_ex  in  1  EX stall request (mult/div busy)
- stallreq_mem  in  1  MEM stall request (dcache miss)
- excp_valid  in  1  exception committed in MEM this cycle
- excp_type  in  32  exception type word from MEM
- cp0_epc  in  32  current EPC, already bypassed
- bpu_flush  in  1  EX-stage branch mispredict
- bpu_target  in  32  correct branch target
- fetch_ready  in  1  fetch accepts the redirect this cycle
- stall  out  4  stage hold vector; bit0 IF, bit1 ID/EX, bit2 MEM, bit3 WB
- flush  out  1  flush pulse
- flush_cause  out  1  1 = Exception (`Exception`), 0 = Branch
- new_pc  out  32  registered redirect target
- redirect_valid  out  1  `new_pc` is valid and awaiting `fetch_ready`
- stall_cycles  out  32  count of cycles with `stall != 0`, wraps
- flush_count  out  16  count of flush pulses, saturates at 16'hFFFF

## Operation
- States: RUN and REDIRECT. Reset enters RUN.
- Stall encoding (combinational) selects the highest requesting stage:
  - `stallreq_mem` gives 4'b0111.
  - `stallreq_ex` gives 4'b0011.
  - `stallreq_id` or `stallreq_if` gives 4'b0001.
  - No request gives 4'b0000.
  - A stage i with `stall[i]=1` and `stall[i+1]=0` emits a bubble downstream.
- In REDIRECT, `stall` is the encoded value OR 4'b0001, so fetch is held.
- Flush arbitration (combinational, in any state):
  - `excp_valid` sets `flush=1` and `flush_cause=1`. Exception has priority over `bpu_flush` because it is the older instruction.
  - Otherwise `bpu_flush` in RUN sets `flush=1` and `flush_cause=0`.
  - `bpu_flush` in REDIRECT is ignored, because EX holds bubbles after a flush.
  - Whenever `flush=1`, `stall` is forced to 4'b0000.
- Target capture at the clock edge of an accepted flush:
  - Exception with `excp_type == ERET_CODE`: `new_pc <= cp0_epc`.
  - Any other exception: `new_pc <= EXC_VECTOR`.
  - Branch flush: `new_pc <= bpu_target`.
  - In all three cases, go to REDIRECT and set `redirect_valid=1`.
- REDIRECT:
  - `fetch_ready=1` with no new exception: return to RUN and set `redirect_valid <= 0`.
  - A new exception overrides `new_pc` and the state stays REDIRECT, even if `fetch_ready=1` in the same cycle.
- Counters:
  - `stall_cycles` increments each cycle the output `stall != 0`, and wraps 32'hFFFFFFFF to 0.
  - `flush_count` increments on each flush cycle and holds at 16'hFFFF.

## Timing
- Reset values: state RUN; `stall` 0; `flush` 0; `flush_cause` 0; `new_pc` 0; `redirect_valid` 0; `stall_cycles` 0; `flush_count` 0.
- Reset mid-REDIRECT returns to RUN and drops `redirect_valid` the next cycle.
- `stall`, `flush` and `flush_cause` are combinational: same-cycle response to their inputs, zero latency.
- `new_pc` and `redirect_valid` are updated at the edge closing the flush cycle. They are visible from cycle N+1 and held stable until the handshake edge.
- Handshake: the transfer happens on the edge where `redirect_valid && fetch_ready`. `fetch_ready` while `redirect_valid=0` has no effect.
- Back-to-back flushes are accepted each cycle, and `flush_count` counts each one.

## Test plan
- `stallreq_ex=1` and `stallreq_if=1` for 3 cycles -> `stall=4'b0011` each cycle; `stall_cycles=3`.
- `excp_valid=1`, `excp_type=32'h4` (not ERET) with `bpu_flush=1` in the same cycle -> `flush=1`, `flush_cause=1`, `stall=0`; next cycle `new_pc=32'hBFC00380`, `redirect_valid=1`.
- `excp_type=32'hE`, `cp0_epc=32'h80001234`; hold `fetch_ready=0` for 2 cycles, then 1 -> `new_pc=32'h80001234` and `stall=4'b0001` while waiting; `redirect_valid` falls after the accepting edge.
- `bpu_flush=1`, `bpu_target=32'h80000040`, then `excp_valid=1` during REDIRECT -> `new_pc` is 32'h80000040, then changes to 32'hBFC00380 with `flush_cause=1`; a `bpu_flush` asserted during REDIRECT is ignored.
- Preload `flush_count=16'hFFFE`, issue 3 flushes -> `flush_count` reads 16'hFFFF; `stall_cycles` wraps from 32'hFFFFFFFF to 0.
- `rst=1` during REDIRECT -> all outputs return to their reset values next cycle.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundle of the pipeline-control signals exchanged between the
// stall/flush controller and the rest of the pipeline.
//   master : pipeline side (drives stall requests, exception/branch info,
//            fetch_ready; observes stall/flush/redirect/counters)
//   slave  : controller side (pipe_ctrl)
interface pipe_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        excp_valid;
    logic [31:0] excp_type;
    logic [31:0] cp0_epc;
    logic        bpu_flush;
    logic [31:0] bpu_target;
    logic        fetch_ready;
    logic [3:0]  stall;
    logic        flush;
    logic        flush_cause;
    logic [31:0] new_pc;
    logic        redirect_valid;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output excp_valid, excp_type, cp0_epc, bpu_flush, bpu_target, fetch_ready,
        input  stall, flush, flush_cause, new_pc, redirect_valid,
        input  stall_cycles, flush_count
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  excp_valid, excp_type, cp0_epc, bpu_flush, bpu_target, fetch_ready,
        output stall, flush, flush_cause, new_pc, redirect_valid,
        output stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush controller for the dual-issue pipeline.
// Merges per-stage stall requests into one hold vector, arbitrates exception
// and branch-mispredict flushes, owns the redirect handshake with fetch and
// keeps stall/flush performance counters.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - pipe_ctrl_if.slave (stall requests, exception/branch inputs,
//          fetch_ready in; stall, flush, flush_cause, new_pc, redirect_valid,
//          stall_cycles, flush_count out)
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter logic [31:0] ERET_CODE  = 32'h0000000E
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);

    typedef enum logic {RUN, REDIRECT} state_t;

    state_t      state_reg, state_next;
    logic [31:0] new_pc_reg, new_pc_next;
    logic [31:0] stall_cycles_reg;
    logic [15:0] flush_count_reg;

    logic [3:0]  stall_enc;
    logic [3:0]  stall_out;
    logic        flush_out;
    logic        cause_out;

    // Highest requesting stage wins; everything upstream of it holds too.
    always_comb begin
        stall_enc = 4'b0000;
        if (bus.stallreq_mem)
            stall_enc = 4'b0111;
        else if (bus.stallreq_ex)
            stall_enc = 4'b0011;
        else if (bus.stallreq_id || bus.stallreq_if)
            stall_enc = 4'b0001;
    end

    // Exception is older than the mispredicted branch, so it wins. A branch
    // flush while redirecting is ignored: EX only holds bubbles then.
    always_comb begin
        flush_out = bus.excp_valid || (bus.bpu_flush && state_reg == RUN);
        cause_out = bus.excp_valid;
        if (flush_out)
            stall_out = 4'b0000;
        else if (state_reg == REDIRECT)
            stall_out = stall_enc | 4'b0001;
        else
            stall_out = stall_enc;
    end

    always_comb begin
        state_next  = state_reg;
        new_pc_next = new_pc_reg;
        if (bus.excp_valid) begin
            // A new exception overrides any pending redirect, even one that
            // fetch is accepting this very cycle.
            new_pc_next = (bus.excp_type == ERET_CODE) ? bus.cp0_epc : EXC_VECTOR;
            state_next  = REDIRECT;
        end else if (state_reg == RUN && bus.bpu_flush) begin
            new_pc_next = bus.bpu_target;
            state_next  = REDIRECT;
        end else if (state_reg == REDIRECT && bus.fetch_ready) begin
            state_next  = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= RUN;
            new_pc_reg       <= 32'h0;
            stall_cycles_reg <= 32'h0;
            flush_count_reg  <= 16'h0;
        end else begin
            state_reg  <= state_next;
            new_pc_reg <= new_pc_next;
            // Wraps naturally at 32 bits.
            if (stall_out != 4'b0000)
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            if (flush_out && flush_count_reg != 16'hFFFF)
                flush_count_reg <= flush_count_reg + 16'd1;
        end
    end

    assign bus.stall          = stall_out;
    assign bus.flush          = flush_out;
    assign bus.flush_cause    = cause_out;
    assign bus.new_pc         = new_pc_reg;
    // Valid exactly while a redirect is pending in the REDIRECT state.
    assign bus.redirect_valid = (state_reg == REDIRECT);
    assign bus.stall_cycles   = stall_cycles_reg;
    assign bus.flush_count    = flush_count_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl. Inputs change on
// the falling edge, outputs are sampled 1ns later, well away from the rising
// edge.
module tb_pipe_ctrl;

    logic clk;
    logic rst;
    int   err_count;
    int   chk_count;

    pipe_ctrl_if bus();

    pipe_ctrl #(
        .EXC_VECTOR(32'hBFC00380),
        .ERET_CODE (32'h0000000E)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("chk  %s: got %h", tag, got);
        end
    endtask

    task automatic clear_inputs();
        bus.stallreq_if  = 1'b0;
        bus.stallreq_id  = 1'b0;
        bus.stallreq_ex  = 1'b0;
        bus.stallreq_mem = 1'b0;
        bus.excp_valid   = 1'b0;
        bus.excp_type    = 32'h0;
        bus.cp0_epc      = 32'h0;
        bus.bpu_flush    = 1'b0;
        bus.bpu_target   = 32'h0;
        bus.fetch_ready  = 1'b0;
    endtask

    initial begin
        err_count = 0;
        chk_count = 0;
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_stall",   {28'h0, bus.stall}, 32'h0);
        check("rst_flush",   {31'h0, bus.flush}, 32'h0);
        check("rst_cause",   {31'h0, bus.flush_cause}, 32'h0);
        check("rst_new_pc",  bus.new_pc, 32'h0);
        check("rst_rv",      {31'h0, bus.redirect_valid}, 32'h0);
        check("rst_scycles", bus.stall_cycles, 32'h0);
        check("rst_fcount",  {16'h0, bus.flush_count}, 32'h0);
        rst = 1'b0;

        // Stall encoding priority, all inside one low phase (no edge passes).
        @(negedge clk);
        bus.stallreq_mem = 1'b1; #1;
        check("enc_mem", {28'h0, bus.stall}, 32'h7);
        bus.stallreq_mem = 1'b0; bus.stallreq_id = 1'b1; #1;
        check("enc_id", {28'h0, bus.stall}, 32'h1);
        bus.stallreq_id = 1'b0; bus.stallreq_ex = 1'b1; bus.stallreq_mem = 1'b1; #1;
        check("enc_ex_mem", {28'h0, bus.stall}, 32'h7);
        clear_inputs(); #1;
        check("enc_none", {28'h0, bus.stall}, 32'h0);

        // EX + IF requests for 3 cycles.
        @(negedge clk);
        bus.stallreq_ex = 1'b1; bus.stallreq_if = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_ex_if", {28'h0, bus.stall}, 32'h3);
            @(negedge clk);
        end
        clear_inputs(); #1;
        check("scycles_3", bus.stall_cycles, 32'd3);

        // Non-ERET exception together with a branch flush.
        @(negedge clk);
        bus.excp_valid = 1'b1; bus.excp_type = 32'h4; bus.bpu_flush = 1'b1;
        bus.bpu_target = 32'h11111111; bus.stallreq_mem = 1'b1; #1;
        check("exc_flush", {31'h0, bus.flush}, 32'h1);
        check("exc_cause", {31'h0, bus.flush_cause}, 32'h1);
        check("exc_stall", {28'h0, bus.stall}, 32'h0);
        @(negedge clk);
        clear_inputs(); #1;
        check("exc_new_pc", bus.new_pc, 32'hBFC00380);
        check("exc_rv", {31'h0, bus.redirect_valid}, 32'h1);
        check("exc_hold_stall", {28'h0, bus.stall}, 32'h1);
        bus.fetch_ready = 1'b1;
        @(negedge clk);
        clear_inputs(); #1;
        check("exc_rv_drop", {31'h0, bus.redirect_valid}, 32'h0);
        check("exc_stall_run", {28'h0, bus.stall}, 32'h0);
        check("exc_fcount", {16'h0, bus.flush_count}, 32'd1);
        check("exc_scycles", bus.stall_cycles, 32'd4);

        // ERET with fetch holding off for 2 cycles.
        @(negedge clk);
        bus.excp_valid = 1'b1; bus.excp_type = 32'hE; bus.cp0_epc = 32'h80001234; #1;
        check("eret_cause", {31'h0, bus.flush_cause}, 32'h1);
        @(negedge clk);
        clear_inputs(); #1;
        check("eret_new_pc", bus.new_pc, 32'h80001234);
        check("eret_rv", {31'h0, bus.redirect_valid}, 32'h1);
        check("eret_wait_stall", {28'h0, bus.stall}, 32'h1);
        @(negedge clk);
        #1;
        check("eret_hold_pc", bus.new_pc, 32'h80001234);
        check("eret_hold_rv", {31'h0, bus.redirect_valid}, 32'h1);
        bus.fetch_ready = 1'b1; bus.stallreq_ex = 1'b1; #1;
        check("eret_ex_stall", {28'h0, bus.stall}, 32'h3);
        @(negedge clk);
        clear_inputs(); #1;
        check("eret_rv_drop", {31'h0, bus.redirect_valid}, 32'h0);
        // fetch_ready while idle must change nothing.
        bus.fetch_ready = 1'b1;
        @(negedge clk);
        clear_inputs(); #1;
        check("idle_ready_rv", {31'h0, bus.redirect_valid}, 32'h0);
        check("idle_ready_pc", bus.new_pc, 32'h80001234);
        check("eret_scycles", bus.stall_cycles, 32'd6);

        // Branch flush, ignored branch in REDIRECT, exception override.
        @(negedge clk);
        bus.bpu_flush = 1'b1; bus.bpu_target = 32'h80000040; #1;
        check("br_flush", {31'h0, bus.flush}, 32'h1);
        check("br_cause", {31'h0, bus.flush_cause}, 32'h0);
        @(negedge clk);
        clear_inputs(); #1;
        check("br_new_pc", bus.new_pc, 32'h80000040);
        check("br_rv", {31'h0, bus.redirect_valid}, 32'h1);
        bus.bpu_flush = 1'b1; bus.bpu_target = 32'h12345678; #1;
        check("br_ignored_flush", {31'h0, bus.flush}, 32'h0);
        check("br_ignored_stall", {28'h0, bus.stall}, 32'h1);
        @(negedge clk);
        clear_inputs(); #1;
        check("br_ignored_pc", bus.new_pc, 32'h80000040);
        bus.excp_valid = 1'b1; bus.excp_type = 32'h4; bus.fetch_ready = 1'b1; #1;
        check("ovr_flush", {31'h0, bus.flush}, 32'h1);
        check("ovr_cause", {31'h0, bus.flush_cause}, 32'h1);
        @(negedge clk);
        clear_inputs(); #1;
        check("ovr_new_pc", bus.new_pc, 32'hBFC00380);
        check("ovr_rv", {31'h0, bus.redirect_valid}, 32'h1);
        bus.fetch_ready = 1'b1;
        @(negedge clk);
        clear_inputs(); #1;
        check("ovr_rv_drop", {31'h0, bus.redirect_valid}, 32'h0);
        check("ovr_fcount", {16'h0, bus.flush_count}, 32'd4);
        check("ovr_scycles", bus.stall_cycles, 32'd8);

        // flush_count saturation: preload FFFE across an idle edge.
        force dut.flush_count_reg = 16'hFFFE;
        @(negedge clk);
        release dut.flush_count_reg;
        #1;
        check("sat_preload", {16'h0, bus.flush_count}, 32'h0000FFFE);
        bus.excp_valid = 1'b1; bus.excp_type = 32'h8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("sat_fcount", {16'h0, bus.flush_count}, 32'h0000FFFF);
        end
        clear_inputs();
        bus.fetch_ready = 1'b1;
        @(negedge clk);
        clear_inputs(); #1;
        check("sat_rv_drop", {31'h0, bus.redirect_valid}, 32'h0);

        // stall_cycles wrap: preload all-ones across an idle edge.
        force dut.stall_cycles_reg = 32'hFFFFFFFF;
        @(negedge clk);
        release dut.stall_cycles_reg;
        #1;
        check("wrap_preload", bus.stall_cycles, 32'hFFFFFFFF);
        bus.stallreq_mem = 1'b1;
        @(negedge clk);
        #1;
        check("wrap_zero", bus.stall_cycles, 32'h0);
        @(negedge clk);
        clear_inputs(); #1;
        check("wrap_one", bus.stall_cycles, 32'h1);

        // Reset in the middle of a redirect.
        bus.bpu_flush = 1'b1; bus.bpu_target = 32'h80000100;
        @(negedge clk);
        clear_inputs(); #1;
        check("rr_rv", {31'h0, bus.redirect_valid}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rr_rv_drop", {31'h0, bus.redirect_valid}, 32'h0);
        check("rr_new_pc", bus.new_pc, 32'h0);
        check("rr_stall", {28'h0, bus.stall}, 32'h0);
        check("rr_scycles", bus.stall_cycles, 32'h0);
        check("rr_fcount", {16'h0, bus.flush_count}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", err_count, chk_count);
        $finish;
    end

endmodule
